// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation codes, the ID/EX
// control bundle and the operand forwarding source selector.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_ADDI = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SLTI = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1110;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // Control bits carried alongside an instruction from decode into execute.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } id_ex_ctrl_t;

  // Where an execute-stage source operand is taken from.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_unit.sv
// Operand forwarding selector: for each execute-stage source register,
// choose between the registered file data, the EX/MEM result and the
// writeback data. The younger EX/MEM producer wins; x0 never forwards.
import riscv_pkg::*;

module fwd_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_t              rs1_sel,
  output fwd_sel_t              rs2_sel
);

  function automatic fwd_sel_t pick(input logic [REG_ADDR_W-1:0] rs);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      sel = FWD_EXM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Select the forwarding source independently for each operand.
  always_comb begin
    rs1_sel = pick(rs1);
    rs2_sel = pick(rs2);
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with execute-side operand forwarding and
// load-use hazard detection. The registered fields plus the forwarding
// buses directly produce the ALU operands and the store data.
import riscv_pkg::*;

module id_ex_fwd_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_a_sel,
  input  logic                     id_b_sel,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic                     id_branch,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic                     exm_reg_write,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  input  logic                     hold,
  output logic                     stall_o,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic                     ex_branch
);

  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [DATA_WIDTH-1:0] ex_rs1_data;
  logic [DATA_WIDTH-1:0] ex_rs2_data;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic                  ex_a_sel;
  logic                  ex_b_sel;
  id_ex_ctrl_t           ex_ctrl;
  id_ex_ctrl_t           id_ctrl;
  logic                  load_use;
  fwd_sel_t              rs1_sel;
  fwd_sel_t              rs2_sel;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // Decode control bits are qualified by id_valid so empty slots never write.
  always_comb begin
    id_ctrl.reg_write  = id_reg_write  & id_valid;
    id_ctrl.mem_read   = id_mem_read   & id_valid;
    id_ctrl.mem_write  = id_mem_write  & id_valid;
    id_ctrl.mem_to_reg = id_mem_to_reg & id_valid;
    id_ctrl.branch     = id_branch     & id_valid;
  end

  // A load in execute whose destination the decoded instruction reads; rs2
  // only counts when it is actually consumed (register operand or store data).
  always_comb begin
    load_use = ex_valid & ex_ctrl.mem_read & (ex_rd != '0) & id_valid &
               ((ex_rd == id_rs1) |
                ((ex_rd == id_rs2) & ~id_b_sel) |
                ((ex_rd == id_rs2) & id_mem_write));
    stall_o  = load_use & ~flush;
  end

  // Pipeline register: flush beats hold, hold beats a load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      Operation   <= ALU_ADD;
      ex_a_sel    <= 1'b0;
      ex_b_sel    <= 1'b0;
      ex_ctrl     <= '0;
    end else if (flush || (!hold && load_use)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      Operation   <= ALU_ADD;
      ex_a_sel    <= 1'b0;
      ex_b_sel    <= 1'b0;
      ex_ctrl     <= '0;
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      Operation   <= id_alu_op;
      ex_a_sel    <= id_a_sel;
      ex_b_sel    <= id_b_sel;
      ex_ctrl     <= id_ctrl;
    end
  end

  fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd (
    .rs1          (ex_rs1),
    .rs2          (ex_rs2),
    .exm_rd       (exm_rd),
    .exm_reg_write(exm_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .rs1_sel      (rs1_sel),
    .rs2_sel      (rs2_sel)
  );

  // Apply the forwarding selection and steer operands into the ALU.
  always_comb begin
    case (rs1_sel)
      FWD_EXM: fwd_rs1 = exm_result;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = ex_rs1_data;
    endcase
    case (rs2_sel)
      FWD_EXM: fwd_rs2 = exm_result;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = ex_rs2_data;
    endcase
    SrcA          = ex_a_sel ? ex_pc  : fwd_rs1;
    SrcB          = ex_b_sel ? ex_imm : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch     = ex_ctrl.branch;

endmodule
